periph_bus_responder: RTL and testbench
=======================================

Name: periph_bus_responder

Overview:
- Memory-mapped peripheral responder answering the CPU MEM stage's load/store requests in the 0x4000_0000 window.
- Holds the timer, LED, switch, 7-segment digit and UART data/control registers.
- Raises the timer interrupt toward the ID stage (irqout).
- Drives a byte-level UART core; the serial core itself sits outside this block.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of the peripheral window; register offsets are word-aligned.
- ADDR_SPAN, 32'h40, window size in bytes. Accesses outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN) are ignored.

Ports:
- clk  in  1  CPU clock
- reset  in  1  asynchronous, active-high reset
- addr  in  32  byte address from ALU result
- wr_data  in  32  store data
- mem_read  in  1  load request this cycle
- mem_write  in  1  store request this cycle
- rd_data  out  32  load data, combinational
- hit  out  1  addr inside window; MEM stage selects rd_data
- switch  in  8  board switches
- led  out  8  LED register
- digi  out  12  digitube register, sent to the scan block
- irqout  out  1  timer interrupt request
- tx_data  out  8  byte to UART core
- tx_start  out  1  one-cycle start pulse to UART core
- tx_busy  in  1  UART core transmitting
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle pulse: rx_data valid

Behaviour:
- Register map (byte offset: name, access):
  - 0x00: TH, RW32
  - 0x04: TL, RW32
  - 0x08: TCON[2:0], RW; bit0 enable, bit1 irq_en, bit2 irq_status
  - 0x0C: LED[7:0], RW
  - 0x10: SWITCH[7:0], RO
  - 0x14: DIGI[11:0], RW
  - 0x18: UART_TXD[7:0], WO (reads the last written byte)
  - 0x1C: UART_RXD[7:0], RO
  - 0x20: UART_CON[2:0]; bit0 rx_ready, bit1 tx_done, bit2 tx_busy (RO mirror)
  - Unused bits read 0. Unmapped in-window offsets: reads 0, writes dropped.
- Reset: all registers 0. Outputs led=0, digi=0, irqout=0, tx_start=0, tx_data=0, rd_data=0.
- Read: rd_data is combinational, zero latency, and 0 when mem_read=0 or hit=0. Registers only change on rising clk.
- Read side effects, applied at the clock edge of the read:
  - Reading UART_RXD clears rx_ready.
  - Reading UART_CON clears tx_done.
- Write: takes effect at the next rising edge. mem_read and mem_write both high: do both; the read sees the old values.
- Timer, when TCON.enable=1, each cycle:
  - TL != 32'hFFFF_FFFF: TL <= TL+1.
  - Else: TL <= TH, and if irq_en=1, irq_status <= 1.
  - irq_status stays set until software writes TCON bit2=0.
  - irqout = irq_en & irq_status.
  - A CPU write to TL or TCON in the same cycle as an overflow wins over the timer update.
  - With enable=0, TL holds.
- UART TX:
  - Write UART_TXD with tx_busy=0: tx_data <= wr_data[7:0], tx_start=1 for exactly one cycle.
  - Write with tx_busy=1: dropped (no start, tx_data unchanged).
  - tx_done sets on the tx_busy 1->0 edge, detected with one registered copy of tx_busy.
  - If a UART_CON read and the tx_done set event land in the same cycle, set wins.
- UART RX:
  - rx_valid: UART_RXD <= rx_data, rx_ready <= 1.
  - rx_valid in the same cycle as a UART_RXD read: the new byte is stored and rx_ready stays 1.
  - A new byte arriving while rx_ready=1 overwrites the old one; no overflow flag.
- Reset mid-operation clears everything, including a pending tx_start. The UART core must treat reset independently.

Decomposition:
- Shared package holds the register offset constants (TH_OFS ... UART_CON_OFS) and the TCON/UART_CON bit index constants, so driver tests and software headers stay consistent.
- One natural sub-module: periph_timer (TH/TL/TCON, overflow reload, irqout). The UART and GPIO registers stay inline.

Test Plan:
- Reset:
  - Assert reset mid-count -> TL=0, TCON=0, irqout=0, led=0 with no clock edge needed.
  - Reads of 0x4000_0000..0x4000_0020 -> 0, except SWITCH = switch input.
- Timer reload:
  - TH=32'hFFFF_FFFD, TL=32'hFFFF_FFFE, TCON=3'b011.
  - Expect TL=FFFF_FFFF after 1 cycle, TL=FFFF_FFFD after 2 cycles, with irq_status=1 and irqout=1 on the same edge.
  - Write TCON=3'b011 -> irqout drops next cycle.
- TX handshake:
  - Write 0x55 to 0x4000_0018 with tx_busy=0 -> one-cycle tx_start, tx_data=0x55.
  - Second write of 0xAA with tx_busy=1 -> no tx_start, tx_data stays 0x55.
  - tx_busy falls -> UART_CON bit1=1 once, cleared after the read.
- RX:
  - Pulse rx_valid with rx_data=0x3C -> UART_CON=3'b001, UART_RXD reads 0x3C, rx_ready then 0.
  - Repeat with rx_valid coinciding with the read -> rx_ready stays 1.
- GPIO / window:
  - Write 0x1A5 to DIGI, 0xF0 to LED -> digi=12'h1A5, led=8'hF0.
  - Write to 0x4000_0040 -> hit=0, no register changes.
- Contention: write TL=0 in the exact overflow cycle -> TL=0 (not TH), irq_status still set.

Source files
------------

// File: rtl/periph_bus_responder_pkg.sv
// Shared register map of the peripheral window: byte offsets and control/status
// bit positions, kept here so driver tests and software headers stay in step.
package periph_bus_responder_pkg;

  localparam logic [31:0] TH_OFS       = 32'h00;
  localparam logic [31:0] TL_OFS       = 32'h04;
  localparam logic [31:0] TCON_OFS     = 32'h08;
  localparam logic [31:0] LED_OFS      = 32'h0C;
  localparam logic [31:0] SWITCH_OFS   = 32'h10;
  localparam logic [31:0] DIGI_OFS     = 32'h14;
  localparam logic [31:0] UART_TXD_OFS = 32'h18;
  localparam logic [31:0] UART_RXD_OFS = 32'h1C;
  localparam logic [31:0] UART_CON_OFS = 32'h20;

  localparam int TCON_EN_BIT     = 0;
  localparam int TCON_IRQ_EN_BIT = 1;
  localparam int TCON_IRQ_ST_BIT = 2;

  localparam int UCON_RX_READY_BIT = 0;
  localparam int UCON_TX_DONE_BIT  = 1;
  localparam int UCON_TX_BUSY_BIT  = 2;

endpackage

// File: rtl/periph_bus_responder_timer.sv
// Reloading 32-bit timer: TL counts up to all-ones, then reloads from TH and
// optionally latches an interrupt status that only software can clear.
module periph_timer
  import periph_bus_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic [31:0] wr_data,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irqout
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        overflow;

  // CPU writes are applied last so they override the count/reload of the same cycle.
  always_comb begin
    overflow = tcon_q[TCON_EN_BIT] && (tl_q == 32'hFFFF_FFFF);
    th_d     = th_we ? wr_data : th_q;
    tl_d     = tl_q;
    tcon_d   = tcon_q;
    if (tcon_q[TCON_EN_BIT]) tl_d = overflow ? th_q : tl_q + 32'd1;
    if (overflow && tcon_q[TCON_IRQ_EN_BIT]) tcon_d[TCON_IRQ_ST_BIT] = 1'b1;
    if (tl_we) tl_d = wr_data;
    if (tcon_we) tcon_d = wr_data[2:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th     = th_q;
  assign tl     = tl_q;
  assign tcon   = tcon_q;
  assign irqout = tcon_q[TCON_IRQ_EN_BIT] & tcon_q[TCON_IRQ_ST_BIT];

endmodule

// File: rtl/periph_bus_responder.sv
// Memory-mapped peripheral responder for the MEM stage: timer, LEDs, switches,
// 7-segment digits and the byte-level register interface of the UART core.
module periph_bus_responder
  import periph_bus_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rd_data,
  output logic        hit,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  logic [31:0] ofs;
  logic        rd_en, wr_en;
  logic [31:0] th, tl;
  logic [2:0]  tcon;

  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_busy_q;

  // The offset compare is done after subtraction so a window at the top of memory cannot wrap.
  assign ofs   = addr - BASE_ADDR;
  assign hit   = (addr >= BASE_ADDR) && (ofs < ADDR_SPAN);
  assign rd_en = mem_read & hit;
  assign wr_en = mem_write & hit;

  periph_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .th_we   (wr_en && (ofs == TH_OFS)),
    .tl_we   (wr_en && (ofs == TL_OFS)),
    .tcon_we (wr_en && (ofs == TCON_OFS)),
    .wr_data (wr_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irqout  (irqout)
  );

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (ofs)
        TH_OFS:       rd_data = th;
        TL_OFS:       rd_data = tl;
        TCON_OFS:     rd_data = {29'd0, tcon};
        LED_OFS:      rd_data = {24'd0, led_q};
        SWITCH_OFS:   rd_data = {24'd0, switch};
        DIGI_OFS:     rd_data = {20'd0, digi_q};
        UART_TXD_OFS: rd_data = {24'd0, tx_data_q};
        UART_RXD_OFS: rd_data = {24'd0, rxd_q};
        UART_CON_OFS: rd_data = {29'd0, tx_busy, tx_done_q, rx_ready_q};
        default:      rd_data = '0;
      endcase
    end
  end

  // Read-to-clear is applied before the hardware set events so a coincident set wins.
  always_comb begin
    led_d      = led_q;
    digi_d     = digi_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rxd_d      = rxd_q;
    rx_ready_d = rx_ready_q;
    tx_done_d  = tx_done_q;
    if (rd_en && (ofs == UART_RXD_OFS)) rx_ready_d = 1'b0;
    if (rd_en && (ofs == UART_CON_OFS)) tx_done_d = 1'b0;
    if (tx_busy_q && !tx_busy) tx_done_d = 1'b1;
    if (rx_valid) begin
      rxd_d      = rx_data;
      rx_ready_d = 1'b1;
    end
    if (wr_en) begin
      case (ofs)
        LED_OFS:  led_d  = wr_data[7:0];
        DIGI_OFS: digi_d = wr_data[11:0];
        UART_TXD_OFS: begin
          if (!tx_busy) begin
            tx_data_d  = wr_data[7:0];
            tx_start_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      digi_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      rxd_q      <= '0;
      rx_ready_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_busy_q  <= 1'b0;
    end else begin
      led_q      <= led_d;
      digi_q     <= digi_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rxd_q      <= rxd_d;
      rx_ready_q <= rx_ready_d;
      tx_done_q  <= tx_done_d;
      tx_busy_q  <= tx_busy;
    end
  end

  assign led      = led_q;
  assign digi     = digi_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_periph_bus_responder.sv
// Scoreboard bench: every bus cycle the reference model pushes its expected
// outputs; a monitor pops and compares them in the middle of the low phase.
`timescale 1ns/10ps
module tb_periph_bus_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0, wr_data = '0, rd_data;
  logic        mem_read = 1'b0, mem_write = 1'b0, hit;
  logic [7:0]  switch = '0, led, tx_data, rx_data = '0;
  logic [11:0] digi;
  logic        irqout, tx_start, tx_busy = 1'b0, rx_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rd;
    logic        hit;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;
    logic        txs;
    logic [7:0]  txd;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state, kept as plain register-map values
  logic [31:0] m_th, m_tl;
  logic        m_en, m_ien, m_ist;
  logic [7:0]  m_led, m_txd, m_rxd;
  logic [11:0] m_digi;
  logic        m_rx_ready, m_tx_done, m_prev_busy, m_start;
  logic        busy_lvl = 1'b0;
  logic [7:0]  sw_lvl = 8'h00;

  periph_bus_responder dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write), .rd_data(rd_data), .hit(hit),
    .switch(switch), .led(led), .digi(digi), .irqout(irqout),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h40);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!in_window(a)) return 32'd0;
    case (a - BASE)
      32'h00: return m_th;
      32'h04: return m_tl;
      32'h08: return {29'd0, m_ist, m_ien, m_en};
      32'h0C: return {24'd0, m_led};
      32'h10: return {24'd0, sw_lvl};
      32'h14: return {20'd0, m_digi};
      32'h18: return {24'd0, m_txd};
      32'h1C: return {24'd0, m_rxd};
      32'h20: return {29'd0, busy_lvl, m_tx_done, m_rx_ready};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_en = 0; m_ien = 0; m_ist = 0;
    m_led = 0; m_txd = 0; m_rxd = 0; m_digi = 0;
    m_rx_ready = 0; m_tx_done = 0; m_prev_busy = 0; m_start = 0;
  endtask

  // One clock edge of the register map, written from the behavioural rules
  task automatic model_step(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic rxv, input logic [7:0] rxb);
    logic [31:0] n_th, n_tl, o;
    logic n_en, n_ien, n_ist, rd_hit, wr_hit;
    o = a - BASE;
    rd_hit = rd && in_window(a);
    wr_hit = wr && in_window(a);
    n_th = m_th; n_tl = m_tl; n_en = m_en; n_ien = m_ien; n_ist = m_ist;
    if (m_en) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        n_tl = m_th;
        if (m_ien) n_ist = 1'b1;
      end else n_tl = m_tl + 1;
    end
    m_start = 1'b0;
    if (rd_hit && o == 32'h1C) m_rx_ready = 1'b0;
    if (rd_hit && o == 32'h20) m_tx_done = 1'b0;
    if (m_prev_busy && !busy_lvl) m_tx_done = 1'b1;
    if (rxv) begin m_rxd = rxb; m_rx_ready = 1'b1; end
    if (wr_hit) begin
      case (o)
        32'h00: n_th = wd;
        32'h04: n_tl = wd;
        32'h08: {n_ist, n_ien, n_en} = wd[2:0];
        32'h0C: m_led = wd[7:0];
        32'h14: m_digi = wd[11:0];
        32'h18: if (!busy_lvl) begin m_txd = wd[7:0]; m_start = 1'b1; end
        default: ;
      endcase
    end
    m_prev_busy = busy_lvl;
    m_th = n_th; m_tl = n_tl; m_en = n_en; m_ien = n_ien; m_ist = n_ist;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic rxv, input logic [7:0] rxb);
    exp_t e;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wr_data = wd;
    rx_valid = rxv; rx_data = rxb; tx_busy = busy_lvl; switch = sw_lvl;
    e.rd   = rd ? model_read(a) : 32'd0;
    e.hit  = in_window(a);
    e.led  = m_led;
    e.digi = m_digi;
    e.irq  = m_ien & m_ist;
    e.txs  = m_start;
    e.txd  = m_txd;
    exp_q.push_back(e);
    model_step(rd, wr, a, wd, rxv, rxb);
  endtask

  task automatic wr_reg(input logic [31:0] o, input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, BASE + o, d, 1'b0, 8'h00);
  endtask

  task automatic rd_reg(input logic [31:0] o);
    applyStimulus(1'b1, 1'b0, BASE + o, 32'd0, 1'b0, 8'h00);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'h00);
  endtask

  // Asynchronous reset between edges; outputs and reads must clear without a clock
  task automatic resetCheck();
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_write = 1'b0; rx_valid = 1'b0; mem_read = 1'b1;
    for (int o = 0; o <= 32'h20; o += 4) begin
      addr = BASE + o;
      #0.3;
      checkOutput("reset_read", rd_data, (o == 32'h10) ? {24'd0, switch} : 32'd0);
    end
    checkOutput("reset_led", {24'd0, led}, 32'd0);
    checkOutput("reset_digi", {20'd0, digi}, 32'd0);
    checkOutput("reset_irqout", {31'd0, irqout}, 32'd0);
    checkOutput("reset_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("reset_tx_data", {24'd0, tx_data}, 32'd0);
    model_reset();
    reset = 1'b0;
    mem_read = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rd_data", rd_data, e.rd);
        checkOutput("hit", {31'd0, hit}, {31'd0, e.hit});
        checkOutput("led", {24'd0, led}, {24'd0, e.led});
        checkOutput("digi", {20'd0, digi}, {20'd0, e.digi});
        checkOutput("irqout", {31'd0, irqout}, {31'd0, e.irq});
        checkOutput("tx_start", {31'd0, tx_start}, {31'd0, e.txs});
        checkOutput("tx_data", {24'd0, tx_data}, {24'd0, e.txd});
      end
    end
  end

  initial begin : stimulus
    logic [31:0] a, d;
    int r;
    model_reset();
    sw_lvl = 8'h5A;
    switch = sw_lvl;
    resetCheck();

    wr_reg(32'h14, 32'h0000_01A5);
    wr_reg(32'h0C, 32'h0000_00F0);
    rd_reg(32'h14);
    rd_reg(32'h0C);
    applyStimulus(1'b1, 1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 1'b0, 8'h00);
    rd_reg(32'h10);

    wr_reg(32'h00, 32'hFFFF_FFFD);
    wr_reg(32'h04, 32'hFFFF_FFFE);
    wr_reg(32'h08, 32'h0000_0003);
    idle();
    rd_reg(32'h04);
    rd_reg(32'h08);
    wr_reg(32'h08, 32'h0000_0003);
    idle();

    wr_reg(32'h08, 32'h0000_0000);
    wr_reg(32'h00, 32'h0000_0005);
    wr_reg(32'h04, 32'hFFFF_FFFE);
    wr_reg(32'h08, 32'h0000_0003);
    idle();
    wr_reg(32'h04, 32'h0000_0000);
    rd_reg(32'h08);
    wr_reg(32'h08, 32'h0000_0000);
    rd_reg(32'h04);

    busy_lvl = 1'b0;
    wr_reg(32'h18, 32'h0000_0055);
    busy_lvl = 1'b1;
    wr_reg(32'h18, 32'h0000_00AA);
    rd_reg(32'h18);
    busy_lvl = 1'b0;
    idle();
    rd_reg(32'h20);
    rd_reg(32'h20);

    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 8'h3C);
    rd_reg(32'h20);
    rd_reg(32'h1C);
    rd_reg(32'h20);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 8'h11);
    applyStimulus(1'b1, 1'b0, BASE + 32'h1C, 32'd0, 1'b1, 8'h22);
    rd_reg(32'h20);
    rd_reg(32'h1C);

    wr_reg(32'h04, 32'd100);
    wr_reg(32'h08, 32'h0000_0007);
    wr_reg(32'h0C, 32'h0000_0033);
    wr_reg(32'h18, 32'h0000_0077);
    resetCheck();
    rd_reg(32'h04);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) busy_lvl = ~busy_lvl;
      sw_lvl = 8'($urandom);
      r = $urandom_range(0, 11);
      if (r <= 9) a = BASE + 32'(r * 4);
      else if (r == 10) a = BASE + 32'h40 + 32'($urandom_range(0, 15) * 4);
      else a = BASE - 32'h4;
      d = $urandom;
      if (a == BASE + 32'h04 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      r = $urandom_range(0, 3);
      applyStimulus(r[0], r[1], a, d, ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
